ct_rtu_arb_rr_8: RTL and testbench

Eight-requester round-robin arbiter with registered, sticky grants, for sharing a single retire-side resource port among eight sources (e.g. PST/ROB-entry writeback slots). The arbiter picks one requester per transaction, holds the grant until the downstream accepts it, then advances its priority pointer past the winner. It drives both a one-hot grant and the equivalent 3-bit binary index.

---
 rtl/ct_rtu_arb_rr_8_pkg.sv | 10 +
 rtl/ct_rtu_arb_rr_8_encode.sv | 16 +
 rtl/ct_rtu_arb_rr_8.sv | 97 +++++++++
 tb/tb_ct_rtu_arb_rr_8.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ct_rtu_arb_rr_8_pkg.sv
// Shared constants and state encoding for the eight-way round-robin retire arbiter.
package ct_rtu_arb_rr_8_pkg;
  localparam int RR_ARB_N     = 8;
  localparam int RR_ARB_IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/ct_rtu_arb_rr_8_encode.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module ct_rtu_encode_8
  import ct_rtu_arb_rr_8_pkg::*;
(
  input  logic [RR_ARB_N-1:0]     onehot,
  output logic [RR_ARB_IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < RR_ARB_N; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
  end

endmodule

// File: rtl/ct_rtu_arb_rr_8.sv
// Eight-requester round-robin arbiter with registered sticky grants.
//   state | meaning
//   IDLE  | no grant presented; arbitrate x_req from ptr
//   GRANT | x_grant held until acked, withdrawn or flushed
module ct_rtu_arb_rr_8
  import ct_rtu_arb_rr_8_pkg::*;
(
  input  logic                    cpuclk,
  input  logic                    cpurst_b,
  input  logic                    rtu_yy_xx_flush,
  input  logic [RR_ARB_N-1:0]     x_req,
  input  logic                    x_dst_ready,
  output logic                    x_grant_vld,
  output logic [RR_ARB_N-1:0]     x_grant,
  output logic [RR_ARB_IDX_W-1:0] x_grant_idx,
  output logic                    x_ack
);

  arb_state_t              state, state_nxt;
  logic [RR_ARB_IDX_W-1:0] ptr, ptr_nxt, idx_nxt, arb_ptr;
  logic [RR_ARB_N-1:0]     grant_nxt, arb_req, rot_req, rot_sel, win;

  assign x_grant_vld = (state == GRANT);
  // No path from x_req: the handshake depends only on held state and ready.
  assign x_ack = (state == GRANT) & x_dst_ready & ~rtu_yy_xx_flush;

  // Back-to-back arbitration masks the bit being acked and starts past it.
  always_comb begin
    if (state == IDLE) begin
      arb_req = x_req;
      arb_ptr = ptr;
    end else begin
      arb_req = x_req & ~x_grant;
      arb_ptr = x_grant_idx + 3'd1;
    end
    rot_req = (arb_req >> arb_ptr) | (arb_req << (4'd8 - {1'b0, arb_ptr}));
    rot_sel = rot_req & (~rot_req + 8'd1);
    win     = (rot_sel << arb_ptr) | (rot_sel >> (4'd8 - {1'b0, arb_ptr}));
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = x_grant;
    if (rtu_yy_xx_flush) begin
      state_nxt = IDLE;
      grant_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (x_req != '0) begin
            state_nxt = GRANT;
            grant_nxt = win;
          end
        end
        GRANT: begin
          if (x_dst_ready) begin
            ptr_nxt = x_grant_idx + 3'd1;
            if (arb_req != '0) begin
              grant_nxt = win;
            end else begin
              state_nxt = IDLE;
              grant_nxt = '0;
            end
          end else if ((x_req & x_grant) == '0) begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      endcase
    end
  end

  ct_rtu_encode_8 u_encode (
    .onehot (grant_nxt),
    .idx    (idx_nxt)
  );

  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
      state       <= IDLE;
      ptr         <= '0;
      x_grant     <= '0;
      x_grant_idx <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      x_grant     <= grant_nxt;
      x_grant_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_ct_rtu_arb_rr_8.sv
// Bench for ct_rtu_arb_rr_8: directed scenarios plus randomized traffic against a behavioural model.
module tb_ct_rtu_arb_rr_8;

  logic       cpuclk = 1'b0;
  logic       cpurst_b = 1'b0;
  logic       rtu_yy_xx_flush = 1'b0;
  logic [7:0] x_req = 8'h00;
  logic       x_dst_ready = 1'b0;
  logic       x_grant_vld;
  logic [7:0] x_grant;
  logic [2:0] x_grant_idx;
  logic       x_ack;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: whether a grant is held, which requester, and where the scan starts next.
  logic m_init = 1'b0;
  logic m_vld  = 1'b0;
  int   m_idx  = 0;
  int   m_ptr  = 0;

  ct_rtu_arb_rr_8 dut (
    .cpuclk          (cpuclk),
    .cpurst_b        (cpurst_b),
    .rtu_yy_xx_flush (rtu_yy_xx_flush),
    .x_req           (x_req),
    .x_dst_ready     (x_dst_ready),
    .x_grant_vld     (x_grant_vld),
    .x_grant         (x_grant),
    .x_grant_idx     (x_grant_idx),
    .x_ack           (x_ack)
  );

  always #5 cpuclk = ~cpuclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rr_first(input logic [7:0] r, input int start);
    int j;
    for (int k = 0; k < 8; k++) begin
      j = (start + k) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge cpuclk) begin
    logic [7:0] rem;
    if (!cpurst_b) begin
      m_init = 1'b1;
      m_vld  = 1'b0;
      m_idx  = 0;
      m_ptr  = 0;
    end else if (rtu_yy_xx_flush) begin
      m_vld = 1'b0;
      m_idx = 0;
    end else if (!m_vld) begin
      if (x_req != 8'h00) begin
        m_vld = 1'b1;
        m_idx = rr_first(x_req, m_ptr);
      end
    end else if (x_dst_ready) begin
      m_ptr = (m_idx + 1) % 8;
      rem = x_req;
      rem[m_idx] = 1'b0;
      if (rem != 8'h00) m_idx = rr_first(rem, m_ptr);
      else begin
        m_vld = 1'b0;
        m_idx = 0;
      end
    end else if (!x_req[m_idx]) begin
      m_vld = 1'b0;
      m_idx = 0;
    end
  end

  always @(negedge cpuclk) begin
    if (m_init) begin
      chk("vld", 32'(x_grant_vld), 32'(m_vld));
      chk("grant", 32'(x_grant), m_vld ? (32'h1 << m_idx) : 32'h0);
      chk("idx", 32'(x_grant_idx), 32'(m_idx));
      chk("ack", 32'(x_ack), 32'(m_vld & x_dst_ready & ~rtu_yy_xx_flush));
    end
  end

  task automatic tick;
    @(negedge cpuclk);
    #1;
  endtask

  initial begin
    tick;
    tick;
    cpurst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_vld", 32'(x_grant_vld), 32'd0);
      chk("idle_grant", 32'(x_grant), 32'h00);
      chk("idle_idx", 32'(x_grant_idx), 32'd0);
    end

    x_req = 8'h81; x_dst_ready = 1'b1;
    tick;
    chk("w81_first_grant", 32'(x_grant), 32'h01);
    chk("w81_first_ack", 32'(x_ack), 32'd1);
    x_req = 8'h80;
    tick;
    chk("w81_second_idx", 32'(x_grant_idx), 32'd7);
    x_req = 8'h00;
    tick;
    chk("w81_idle", 32'(x_grant_vld), 32'd0);

    x_req = 8'hFF;
    for (int k = 0; k <= 10; k++) begin
      tick;
      chk("ff_seq_idx", 32'(x_grant_idx), 32'(k % 8));
      chk("ff_seq_ack", 32'(x_ack), 32'd1);
    end

    x_dst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("hold_grant", 32'(x_grant), 32'h04);
      chk("hold_idx", 32'(x_grant_idx), 32'd2);
      chk("hold_ack", 32'(x_ack), 32'd0);
    end
    x_req = 8'hC4; x_dst_ready = 1'b1;
    #1;
    chk("hold_release_ack", 32'(x_ack), 32'd1);
    tick;
    chk("after_ptr3_idx", 32'(x_grant_idx), 32'd6);

    x_dst_ready = 1'b0; x_req = 8'h00;
    tick;
    chk("withdraw6_idle", 32'(x_grant_vld), 32'd0);
    x_req = 8'h21;
    tick;
    chk("grant5_idx", 32'(x_grant_idx), 32'd5);
    x_req = 8'h01;
    tick;
    chk("withdraw5_idle", 32'(x_grant_vld), 32'd0);
    x_req = 8'h21;
    tick;
    chk("regrant5_idx", 32'(x_grant_idx), 32'd5);

    rtu_yy_xx_flush = 1'b1; x_dst_ready = 1'b1;
    #1;
    chk("flush_ack", 32'(x_ack), 32'd0);
    tick;
    chk("flush_idle", 32'(x_grant_vld), 32'd0);
    rtu_yy_xx_flush = 1'b0; x_dst_ready = 1'b0;
    tick;
    chk("post_flush_idx", 32'(x_grant_idx), 32'd5);

    cpurst_b = 1'b0;
    tick;
    chk("rst_vld", 32'(x_grant_vld), 32'd0);
    chk("rst_grant", 32'(x_grant), 32'h00);
    chk("rst_idx", 32'(x_grant_idx), 32'd0);
    cpurst_b = 1'b1;
    tick;
    chk("post_rst_idx", 32'(x_grant_idx), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) x_req = 8'($urandom) & 8'($urandom);
      x_dst_ready     = ($urandom_range(0, 2) != 0);
      rtu_yy_xx_flush = ($urandom_range(0, 15) == 0);
      cpurst_b        = ($urandom_range(0, 199) != 0);
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
